// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-side arbiter: merges ALU and LSU results onto one
// registered write port, buffers LSU results in a FIFO, tracks pending loads.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_value    ALU result, fixed priority, no backpressure
//   lsu_valid/lsu_ready           LSU result handshake (ready = FIFO not full)
//   lsu_rd/lsu_value              LSU result payload
//   issue_valid/issue_rd          load issue, marks issue_rd pending
//   query_rs1/query_rs2           decode source registers for hazard check
//   rs1_busy/rs2_busy/issue_busy  combinational pending lookups
//   wr_en/rd/rd_value             registered regfile write port
module regfile_writeback_arbiter #(
    parameter int LSU_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_value,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_value,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      query_rs1,
    input  logic [4:0]      query_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            issue_busy,
    output logic            wr_en,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_value
);

    localparam int PW = $clog2(LSU_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      r_q_rd  [LSU_DEPTH];
    logic [XLEN-1:0] r_q_val [LSU_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_pending;

    logic            w_alu_win;
    logic            w_pop;
    logic            w_push;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;

    // Ready comes only from the registered count, so a pop in a full
    // cycle cannot admit a push in that same cycle.
    assign lsu_ready = (r_count != CW'(LSU_DEPTH));

    // An ALU result targeting x0 is treated as idle so the FIFO may drain.
    assign w_alu_win = alu_valid && (alu_rd != 5'd0);
    assign w_pop     = !w_alu_win && (r_count != '0);
    assign w_push    = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

    assign rs1_busy   = r_pending[query_rs1];
    assign rs2_busy   = r_pending[query_rs2];
    assign issue_busy = r_pending[issue_rd];

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid) begin
            w_set[issue_rd] = 1'b1;
        end
        if (w_pop) begin
            w_clr[r_q_rd[r_rptr]] = 1'b1;
        end
        w_set[0] = 1'b0;
    end

    // FIFO storage carries no reset; the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wptr]  <= lsu_rd;
            r_q_val[r_wptr] <= lsu_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_pending <= '0;
            wr_en     <= 1'b0;
            rd        <= 5'd0;
            rd_value  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Set is applied after clear so a same-cycle set wins.
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_alu_win) begin
                wr_en    <= 1'b1;
                rd       <= alu_rd;
                rd_value <= alu_value;
            end else if (w_pop) begin
                wr_en    <= 1'b1;
                rd       <= r_q_rd[r_rptr];
                rd_value <= r_q_val[r_rptr];
            end else begin
                wr_en    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Testbench for regfile_writeback_arbiter: directed scenarios plus a
// randomized run checked against a queue-based behavioural model.
module tb_regfile_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_value;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_value;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      query_rs1;
    logic [4:0]      query_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            issue_busy;
    logic            wr_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_value;

    always #5 clk = ~clk;

    regfile_writeback_arbiter #(
        .LSU_DEPTH(DEPTH),
        .XLEN(XLEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_value(alu_value),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd),
        .lsu_value(lsu_value),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .query_rs1(query_rs1),
        .query_rs2(query_rs2),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .issue_busy(issue_busy),
        .wr_en(wr_en),
        .rd(rd),
        .rd_value(rd_value)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] v;
    } ent_t;

    // Reference model: queue of accepted LSU results, pending flags and
    // the expected write port.
    ent_t            q[$];
    bit   [31:0]     m_pend;
    bit              m_wr;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_val;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_value   = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = 5'd0;
        lsu_value   = '0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        query_rs1   = 5'd0;
        query_rs2   = 5'd0;
    endtask

    // Advance the model using the inputs present before the edge, then
    // step the clock and settle just after the edge.
    task automatic tick();
        ent_t e;
        bit   acc;
        if (rst) begin
            q.delete();
            m_pend = '0;
            m_wr   = 1'b0;
            m_rd   = 5'd0;
            m_val  = '0;
        end else begin
            acc = lsu_valid && (q.size() < DEPTH);
            if (alu_valid && alu_rd != 5'd0) begin
                m_wr  = 1'b1;
                m_rd  = alu_rd;
                m_val = alu_value;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_wr  = 1'b1;
                m_rd  = e.rd;
                m_val = e.v;
                m_pend[e.rd] = 1'b0;
            end else begin
                m_wr = 1'b0;
            end
            if (acc && lsu_rd != 5'd0) begin
                e.rd = lsu_rd;
                e.v  = lsu_value;
                q.push_back(e);
            end
            if (issue_valid && issue_rd != 5'd0) begin
                m_pend[issue_rd] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({wr_en, rd, rd_value} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got %0b/%0d/%0h want 0/0/0",
                     wr_en, rd, rd_value);
        end
        n_cmp++;
        if (lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b want 1", lsu_ready);
        end
    endtask

    task automatic test_alu_basic();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_value = 32'h1234;
        tick();
        idle_inputs();
        n_cmp++;
        if (wr_en !== 1'b1 || rd !== 5'd5 || rd_value !== 32'h1234) begin
            n_fail++;
            $display("FAIL alu_basic: got %0b/%0d/%0h want 1/5/1234",
                     wr_en, rd, rd_value);
        end
        tick();
    endtask

    task automatic test_load_hazard();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        query_rs1   = 5'd7;
        tick();
        issue_valid = 1'b0;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_set: got %0b want 1", rs1_busy);
        end
        lsu_valid = 1'b1;
        lsu_rd    = 5'd7;
        lsu_value = 32'hDEAD;
        tick();
        lsu_valid = 1'b0;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_wait: got busy=%0b wr=%0b want 1/0",
                     rs1_busy, wr_en);
        end
        tick();
        n_cmp++;
        if (wr_en !== 1'b1 || rd !== 5'd7 || rd_value !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL hazard_write: got %0b/%0d/%0h want 1/7/dead",
                     wr_en, rd, rd_value);
        end
        n_cmp++;
        if (rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_clear: got %0b want 0", rs1_busy);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_fifo_full();
        alu_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            alu_rd    = 5'd1;
            alu_value = 32'(k);
            lsu_valid = 1'b1;
            lsu_rd    = 5'(20 + k);
            lsu_value = 32'hA000 + 32'(k);
            #1;
            n_cmp++;
            if (lsu_ready !== (k < 4)) begin
                n_fail++;
                $display("FAIL full_ready[%0d]: got %0b want %0b",
                         k, lsu_ready, (k < 4));
            end
            tick();
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (wr_en !== 1'b1 || rd !== 5'd20 || rd_value !== 32'hA000) begin
            n_fail++;
            $display("FAIL full_pop: got %0b/%0d/%0h want 1/20/a000",
                     wr_en, rd, rd_value);
        end
        n_cmp++;
        if (lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_reready: got %0b want 1", lsu_ready);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            n_cmp++;
            if (wr_en !== 1'b1 || rd !== 5'(20 + k)) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %0b/%0d want 1/%0d",
                         k, wr_en, rd, 20 + k);
            end
        end
        tick();
    endtask

    task automatic test_alu_rd0();
        lsu_valid = 1'b1;
        lsu_rd    = 5'd3;
        lsu_value = 32'h3333;
        tick();
        lsu_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_value = 32'hBAD0;
        tick();
        n_cmp++;
        if (wr_en !== 1'b1 || rd !== 5'd3 || rd_value !== 32'h3333) begin
            n_fail++;
            $display("FAIL alu_rd0: got %0b/%0d/%0h want 1/3/3333",
                     wr_en, rd, rd_value);
        end
        tick();
        n_cmp++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_rd0_idle: got wr=%0b rd=%0d want wr 0",
                     wr_en, rd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lsu_rd0();
        lsu_valid = 1'b1;
        lsu_rd    = 5'd0;
        lsu_value = 32'h5555;
        #1;
        n_cmp++;
        if (lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lsu_rd0_ready: got %0b want 1", lsu_ready);
        end
        tick();
        lsu_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (wr_en !== 1'b0 || lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lsu_rd0_nowrite: got wr=%0b rdy=%0b want 0/1",
                     wr_en, lsu_ready);
        end
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        for (int k = 0; k < 3; k++) begin
            lsu_valid   = 1'b1;
            lsu_rd      = 5'(12 + k);
            lsu_value   = 32'hC000 + 32'(k);
            issue_valid = (k < 2);
            issue_rd    = 5'(10 + k);
            tick();
        end
        idle_inputs();
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        query_rs1 = 5'd10;
        query_rs2 = 5'd11;
        issue_rd  = 5'd10;
        #1;
        n_cmp++;
        if ({rs1_busy, rs2_busy, issue_busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_rst_busy: got %0b%0b%0b want 111",
                     rs1_busy, rs2_busy, issue_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alu_valid = 1'b0;
        #1;
        n_cmp++;
        if (wr_en !== 1'b0 || lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_out: got wr=%0b rdy=%0b want 0/1",
                     wr_en, lsu_ready);
        end
        n_cmp++;
        if ({rs1_busy, rs2_busy, issue_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_rst_busy: got %0b%0b%0b want 000",
                     rs1_busy, rs2_busy, issue_busy);
        end
        lsu_valid = 1'b1;
        lsu_rd    = 5'd9;
        lsu_value = 32'h9999;
        tick();
        lsu_valid = 1'b0;
        tick();
        n_cmp++;
        if (wr_en !== 1'b1 || rd !== 5'd9 || rd_value !== 32'h9999) begin
            n_fail++;
            $display("FAIL post_rst_write: got %0b/%0d/%0h want 1/9/9999",
                     wr_en, rd, rd_value);
        end
        tick();
        n_cmp++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_empty: got wr=%0b rd=%0d want 0",
                     wr_en, rd);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_rd      = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom);
            alu_value   = $urandom;
            lsu_valid   = ($urandom_range(0, 1) == 0);
            lsu_rd      = 5'($urandom);
            lsu_value   = $urandom;
            issue_rd    = 5'($urandom);
            issue_valid = ($urandom_range(0, 2) == 0) && !m_pend[issue_rd];
            query_rs1   = 5'($urandom);
            query_rs2   = 5'($urandom);
            #1;
            n_cmp++;
            if (lsu_ready !== (q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL rnd_ready[%0d]: got %0b want %0b",
                         c, lsu_ready, (q.size() < DEPTH));
            end
            n_cmp++;
            if (rs1_busy !== m_pend[query_rs1] ||
                rs2_busy !== m_pend[query_rs2] ||
                issue_busy !== m_pend[issue_rd]) begin
                n_fail++;
                $display("FAIL rnd_busy[%0d]: got %0b%0b%0b want %0b%0b%0b",
                         c, rs1_busy, rs2_busy, issue_busy,
                         m_pend[query_rs1], m_pend[query_rs2],
                         m_pend[issue_rd]);
            end
            tick();
            n_cmp++;
            if (wr_en !== m_wr ||
                (m_wr && (rd !== m_rd || rd_value !== m_val))) begin
                n_fail++;
                $display("FAIL rnd_write[%0d]: got %0b/%0d/%0h want %0b/%0d/%0h",
                         c, wr_en, rd, rd_value, m_wr, m_rd, m_val);
            end
            n_cmp++;
            if (wr_en === 1'b1 && rd === 5'd0) begin
                n_fail++;
                $display("FAIL rnd_rd0[%0d]: got wr 1 rd 0 want rd!=0", c);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        m_pend = '0;
        m_wr   = 1'b0;
        m_rd   = 5'd0;
        m_val  = '0;
        test_reset();
        test_alu_basic();
        test_load_hazard();
        test_fifo_full();
        test_alu_rd0();
        test_lsu_rd0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
